// File: rtl/alu_mdu_pkg.sv
// Shared RV32 decode types, opcode/funct constants and state/op enums for alu_mdu.
package alu_mdu_pkg;

   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } instruction_t;

   localparam logic [6:0] OP_MATH     = 7'b0110011;
   localparam logic [6:0] OP_MATH_IMM = 7'b0010011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_ADD  = 3'd0;
   localparam logic [2:0] F3_SLL  = 3'd1;
   localparam logic [2:0] F3_SLT  = 3'd2;
   localparam logic [2:0] F3_SLTU = 3'd3;
   localparam logic [2:0] F3_XOR  = 3'd4;
   localparam logic [2:0] F3_SR   = 3'd5;
   localparam logic [2:0] F3_OR   = 3'd6;
   localparam logic [2:0] F3_AND  = 3'd7;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_mdu_state_t;

   // Encoded to match funct3 so decode is a plain cast.
   typedef enum logic [2:0] {
      MDU_MUL    = 3'd0,
      MDU_MULH   = 3'd1,
      MDU_MULHSU = 3'd2,
      MDU_MULHU  = 3'd3,
      MDU_DIV    = 3'd4,
      MDU_DIVU   = 3'd5,
      MDU_REM    = 3'd6,
      MDU_REMU   = 3'd7
   } mdu_op_t;

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative RV32M core: shift-add multiply / restoring divide on magnitudes, STEP_BITS per cycle,
// sign fix-up applied to the final step so the result is ready on the last busy edge.
module mdu_iter_core
   import alu_mdu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STEP_BITS  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  mdu_op_t               op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  done_c,
   output logic [DATA_WIDTH-1:0] result_c
);
   localparam int unsigned STEPS = DATA_WIDTH / STEP_BITS;
   localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam int unsigned PW    = 2 * DATA_WIDTH;
   localparam int unsigned XW    = DATA_WIDTH + STEP_BITS;

   logic                  busy, mul_mode, hi_sel, rem_sel, neg_q, neg_r;
   logic [CW-1:0]         cnt;
   logic [DATA_WIDTH-1:0] opb, mag_a, mag_b, rem, quo, q, r;
   logic [PW-1:0]         acc, acc_nxt, prod;
   logic [XW-1:0]         partial, upper;
   logic [DATA_WIDTH:0]   trial;
   logic                  sa, sb, is_mul;

   // Operand signedness and magnitudes at start.
   always_comb begin
      is_mul = op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU};
      sa     = (op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM}) & a[DATA_WIDTH-1];
      sb     = (op inside {MDU_MULH, MDU_DIV, MDU_REM}) & b[DATA_WIDTH-1];
      mag_a  = sa ? -a : a;
      mag_b  = sb ? -b : b;
   end

   // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
   always_comb begin
      acc_nxt = acc;
      partial = '0;
      upper   = '0;
      rem     = acc[PW-1:DATA_WIDTH];
      quo     = acc[DATA_WIDTH-1:0];
      trial   = '0;
      if (mul_mode) begin
         partial = XW'(opb) * XW'(acc[STEP_BITS-1:0]);
         upper   = XW'(acc[PW-1:DATA_WIDTH]) + partial;
         acc_nxt = {upper, acc[DATA_WIDTH-1:STEP_BITS]};
      end else begin
         for (int i = 0; i < STEP_BITS; i++) begin
            trial = {rem, quo[DATA_WIDTH-1]};
            if (trial >= {1'b0, opb}) begin
               rem = DATA_WIDTH'(trial - {1'b0, opb});
               quo = {quo[DATA_WIDTH-2:0], 1'b1};
            end else begin
               rem = trial[DATA_WIDTH-1:0];
               quo = {quo[DATA_WIDTH-2:0], 1'b0};
            end
         end
         acc_nxt = {rem, quo};
      end
   end

   always_comb begin
      prod     = neg_q ? -acc_nxt : acc_nxt;
      q        = acc_nxt[DATA_WIDTH-1:0];
      r        = acc_nxt[PW-1:DATA_WIDTH];
      result_c = neg_q ? -q : q;
      if (mul_mode)     result_c = hi_sel ? prod[PW-1:DATA_WIDTH] : prod[DATA_WIDTH-1:0];
      else if (rem_sel) result_c = neg_r ? -r : r;
      done_c   = busy && (cnt == CW'(STEPS - 1));
   end

   // Divide-by-zero keeps the quotient un-negated so it stays all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         cnt      <= '0;
         mul_mode <= 1'b0;
         hi_sel   <= 1'b0;
         rem_sel  <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         opb      <= '0;
         acc      <= '0;
      end else if (start) begin
         busy     <= 1'b1;
         cnt      <= '0;
         mul_mode <= is_mul;
         hi_sel   <= (op != MDU_MUL);
         rem_sel  <= (op == MDU_REM) || (op == MDU_REMU);
         neg_q    <= (sa ^ sb) & (is_mul | (b != '0));
         neg_r    <= sa;
         opb      <= is_mul ? mag_a : mag_b;
         acc      <= {{DATA_WIDTH{1'b0}}, (is_mul ? mag_b : mag_a)};
      end else if (busy) begin
         acc <= acc_nxt;
         cnt <= cnt + CW'(1);
         if (done_c) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_mdu.sv
// RV32 execute unit: single-cycle base ALU plus iterative RV32M with valid/ready on both sides.
// Define ALU_MDU_MULDIV_EN to build the multiply/divide path; otherwise M ops decode as illegal.
module alu_mdu
   import alu_mdu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned INSTR_WIDTH = 32,
   parameter int unsigned STEP_BITS   = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  alu_op1,
   input  logic [DATA_WIDTH-1:0]  alu_op2,
   input  logic [INSTR_WIDTH-1:0] instr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  alu_out,
   output logic                   illegal_op
);
   localparam int unsigned SHW              = $clog2(DATA_WIDTH);
   localparam int unsigned unused_step_bits = STEP_BITS;

   instruction_t          ins;
   alu_mdu_state_t        state, state_nxt;
   logic                  rdy_en, accept, legal, dec_m, core_start, core_done;
   logic                  is_r, is_i, f7_base, f7_alt;
   logic [DATA_WIDTH-1:0] base_res, core_res;
   logic [SHW-1:0]        shamt;
   logic                  unused_fields;

   assign ins           = instruction_t'(instr);
   assign unused_fields = ^{ins.rs1, ins.rs2, ins.rd};

   // Decode and base-ALU datapath; I-type immediate arrives pre-extended on alu_op2.
   always_comb begin
      is_r     = (ins.opcode == OP_MATH);
      is_i     = (ins.opcode == OP_MATH_IMM);
      f7_base  = (ins.funct7 == F7_BASE);
      f7_alt   = (ins.funct7 == F7_ALT);
      shamt    = alu_op2[SHW-1:0];
      base_res = '0;
      legal    = 1'b0;
      dec_m    = 1'b0;
      if (is_r && ins.funct7 == F7_MULDIV) begin
`ifdef ALU_MDU_MULDIV_EN
         legal = 1'b1;
         dec_m = 1'b1;
`endif
      end else if (is_r || is_i) begin
         unique case (ins.funct3)
            F3_ADD: begin
               legal    = is_i | f7_base | f7_alt;
               base_res = (is_r && f7_alt) ? alu_op1 - alu_op2 : alu_op1 + alu_op2;
            end
            F3_SLL: begin
               legal    = f7_base;
               base_res = alu_op1 << shamt;
            end
            F3_SLT: begin
               legal    = is_i | f7_base;
               base_res = DATA_WIDTH'($signed(alu_op1) < $signed(alu_op2));
            end
            F3_SLTU: begin
               legal    = is_i | f7_base;
               base_res = DATA_WIDTH'(alu_op1 < alu_op2);
            end
            F3_XOR: begin
               legal    = is_i | f7_base;
               base_res = alu_op1 ^ alu_op2;
            end
            F3_SR: begin
               legal    = f7_base | f7_alt;
               base_res = f7_alt ? $unsigned($signed(alu_op1) >>> shamt) : alu_op1 >> shamt;
            end
            F3_OR: begin
               legal    = is_i | f7_base;
               base_res = alu_op1 | alu_op2;
            end
            F3_AND: begin
               legal    = is_i | f7_base;
               base_res = alu_op1 & alu_op2;
            end
            default: ;
         endcase
      end
      if (!legal) base_res = '0;
   end

`ifdef ALU_MDU_MULDIV_EN
   mdu_iter_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .STEP_BITS  (STEP_BITS)
   ) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (core_start),
      .op       (mdu_op_t'(ins.funct3)),
      .a        (alu_op1),
      .b        (alu_op2),
      .done_c   (core_done),
      .result_c (core_res)
   );
`else
   assign core_done = 1'b0;
   assign core_res  = '0;
`endif

   // rdy_en holds off in_ready for the first cycle after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         rdy_en <= 1'b0;
      end else begin
         state  <= state_nxt;
         rdy_en <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = dec_m ? BUSY : DONE;
         BUSY:    if (core_done) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = accept ? (dec_m ? BUSY : DONE) : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready   = rdy_en && ((state == IDLE) || (state == DONE && out_ready));
      accept     = in_valid && in_ready;
      core_start = accept && dec_m;
   end

   // Result register: held while out_valid & !out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         alu_out    <= '0;
         illegal_op <= 1'b0;
      end else if (accept && !dec_m) begin
         out_valid  <= 1'b1;
         alu_out    <= base_res;
         illegal_op <= !legal;
      end else if (accept) begin
         out_valid  <= 1'b0;
      end else if (state == BUSY && core_done) begin
         out_valid  <= 1'b1;
         alu_out    <= core_res;
         illegal_op <= 1'b0;
      end else if (state == DONE && out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule
